// File: rtl/decode_pkg.sv
// Shared decode types: ALU operation encoding, opcode values and the decoded bundle.
package decode_pkg;

   // Address fields are stored at a fixed maximum width; the stage narrows them to its own AW.
   localparam int unsigned ADDR_MAX_W = 8;

   typedef enum logic [3:0] {
      ALU_AND  = 4'd0,
      ALU_SLT  = 4'd1,
      ALU_OR   = 4'd2,
      ALU_ADD  = 4'd4,
      ALU_SUB  = 4'd5,
      ALU_PASS = 4'd6,
      ALU_EQ   = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9,
      ALU_SLL  = 4'd10
   } alu_op_e;

   localparam logic [2:0] OP_ALU   = 3'b000;
   localparam logic [2:0] OP_MEM   = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_ADDI  = 3'b011;
   localparam logic [2:0] OP_TR    = 3'b100;
   localparam logic [2:0] OP_BEQ   = 3'b101;
   localparam logic [2:0] OP_SUB   = 3'b110;
   localparam logic [2:0] OP_SHIFT = 3'b111;

   typedef struct packed {
      alu_op_e               alu_op;
      logic [ADDR_MAX_W-1:0] rs;
      logic [ADDR_MAX_W-1:0] rt;
      logic [ADDR_MAX_W-1:0] rd;
      logic [3:0]            imm;
      logic                  reg_write;
      logic                  sel_imm;
      logic                  mem_read;
      logic                  mem_write;
      logic                  mem2reg;
      logic                  branch;
      logic                  jump;
      logic                  halt;
      logic                  illegal;
   } ctrl_t;

   function automatic logic [ADDR_MAX_W-1:0] trunc_addr(input int unsigned sum,
                                                        input int unsigned aw);
      logic [31:0] mask;
      mask = (32'd1 << aw) - 32'd1;
      return ADDR_MAX_W'(sum & mask);
   endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational decoder: one instruction word in, one control bundle out.
module decode_comb
   import decode_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 12,
   parameter int unsigned INSTR_WIDTH = 9,
   parameter int unsigned RS_BASE     = 4,
   parameter int unsigned HI_BASE     = 8,
   parameter int unsigned ACC_REG     = 11
) (
   input  logic [INSTR_WIDTH-1:0] instr,
   output ctrl_t                  ctrl,
   output logic                   rt_used
);

   localparam int unsigned AW = $clog2(NUM_REGS);

   logic [2:0]  op;
   logic [1:0]  fld_s;
   logic [1:0]  fld_a;
   logic [1:0]  fld_b;
   int unsigned rs_sum;
   int unsigned rt_sum;
   int unsigned rd_sum;
   logic        bad_op;
   logic        bad_addr;
   logic        bad_upper;

   assign op    = instr[8:6];
   assign fld_a = instr[5:4];
   assign fld_b = instr[3:2];
   assign fld_s = instr[1:0];

   // Sums are kept wide so an out-of-range register is caught before narrowing to AW bits.
   always_comb begin
      ctrl      = '0;
      rt_used   = 1'b0;
      rs_sum    = 32'd0;
      rt_sum    = 32'd0;
      rd_sum    = 32'd0;
      bad_op    = 1'b0;
      bad_upper = (instr >> 9) != '0;

      case (op)
         OP_ALU: begin
            rs_sum         = 32'(fld_a) + RS_BASE;
            rt_sum         = 32'(fld_b);
            rd_sum         = ACC_REG;
            rt_used        = 1'b1;
            ctrl.reg_write = 1'b1;
            case (fld_s)
               2'd0: ctrl.alu_op = ALU_AND;
               2'd1: begin
                  ctrl.alu_op = ALU_SLT;
                  rt_sum      = 32'(fld_b) + HI_BASE;
               end
               2'd2: ctrl.alu_op = ALU_OR;
               default: begin
                  ctrl.alu_op    = ALU_PASS;
                  ctrl.jump      = 1'b1;
                  ctrl.reg_write = 1'b0;
               end
            endcase
         end
         OP_MEM: begin
            rs_sum      = 32'(fld_a) + RS_BASE;
            ctrl.alu_op = ALU_PASS;
            case (fld_s)
               2'd0: begin
                  rd_sum         = 32'(fld_b);
                  ctrl.mem_read  = 1'b1;
                  ctrl.mem2reg   = 1'b1;
                  ctrl.reg_write = 1'b1;
               end
               2'd1: begin
                  rt_sum         = 32'(fld_b);
                  rt_used        = 1'b1;
                  ctrl.mem_write = 1'b1;
               end
               default: bad_op = 1'b1;
            endcase
         end
         OP_ADD, OP_SUB: begin
            rs_sum         = 32'(fld_a) + RS_BASE;
            rt_sum         = 32'(fld_b);
            rd_sum         = 32'(fld_s) + HI_BASE;
            rt_used        = 1'b1;
            ctrl.alu_op    = (op == OP_ADD) ? ALU_ADD : ALU_SUB;
            ctrl.reg_write = 1'b1;
         end
         OP_ADDI: begin
            rs_sum         = 32'(fld_a) + RS_BASE;
            rd_sum         = rs_sum;
            ctrl.imm       = instr[3:0];
            ctrl.sel_imm   = 1'b1;
            ctrl.alu_op    = ALU_ADD;
            ctrl.reg_write = 1'b1;
         end
         OP_TR: begin
            rs_sum         = 32'(instr[2:0]) + RS_BASE;
            rd_sum         = 32'(instr[5:3]);
            ctrl.alu_op    = ALU_PASS;
            ctrl.reg_write = 1'b1;
         end
         OP_BEQ: begin
            rs_sum      = 32'(fld_a) + RS_BASE;
            rt_sum      = 32'(fld_b);
            rt_used     = 1'b1;
            ctrl.alu_op = ALU_EQ;
            ctrl.branch = 1'b1;
         end
         default: begin
            rs_sum         = 32'(fld_a) + RS_BASE;
            rd_sum         = rs_sum;
            rt_sum         = 32'(fld_b);
            rt_used        = 1'b1;
            ctrl.reg_write = 1'b1;
            case (fld_s)
               2'd0: ctrl.alu_op = ALU_SRL;
               2'd1: ctrl.alu_op = ALU_SRA;
               2'd2: ctrl.alu_op = ALU_SLL;
               default: begin
                  ctrl.halt      = 1'b1;
                  ctrl.reg_write = 1'b0;
               end
            endcase
         end
      endcase

      bad_addr = (rs_sum >= NUM_REGS) || (rt_sum >= NUM_REGS) || (rd_sum >= NUM_REGS);
      ctrl.rs  = trunc_addr(rs_sum, AW);
      ctrl.rt  = trunc_addr(rt_sum, AW);
      ctrl.rd  = trunc_addr(rd_sum, AW);

      // Illegal words still flow downstream, but can never change architectural state.
      ctrl.illegal = bad_op || bad_addr || bad_upper;
      if (ctrl.illegal) begin
         ctrl.reg_write = 1'b0;
         ctrl.mem_read  = 1'b0;
         ctrl.mem_write = 1'b0;
         ctrl.mem2reg   = 1'b0;
         ctrl.branch    = 1'b0;
         ctrl.jump      = 1'b0;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked decode stage with sticky halt and load-use stall.
// Define DECODE_PERF_EN to add the perf_decoded / perf_stalls counters.
module decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 12,
   parameter int unsigned INSTR_WIDTH = 9,
   parameter int unsigned REG_WIDTH   = 8,
   parameter int unsigned RS_BASE     = 4,
   parameter int unsigned HI_BASE     = 8,
   parameter int unsigned ACC_REG     = 11,
   localparam int unsigned AW         = $clog2(NUM_REGS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_WIDTH-1:0] instr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [3:0]             alu_op,
   output logic [AW-1:0]          rs_addr,
   output logic [AW-1:0]          rt_addr,
   output logic [AW-1:0]          rd_addr,
   output logic [REG_WIDTH-1:0]   imm,
   output logic                   reg_write,
   output logic                   sel_imm,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic                   mem2reg,
   output logic                   branch,
   output logic                   jump,
   output logic                   halt,
   output logic                   illegal,
   output logic                   halted
`ifdef DECODE_PERF_EN
   ,
   output logic [31:0]            perf_decoded,
   output logic [31:0]            perf_stalls
`endif
);

   ctrl_t dec;
   ctrl_t bundle_q;
   ctrl_t bundle_d;
   logic  dec_rt_used;
   logic  out_valid_q;
   logic  out_valid_d;
   logic  halted_q;
   logic  halted_d;
   logic  rs_hit;
   logic  rt_hit;
   logic  hazard;
   logic  accept;

   decode_comb #(
      .NUM_REGS    (NUM_REGS),
      .INSTR_WIDTH (INSTR_WIDTH),
      .RS_BASE     (RS_BASE),
      .HI_BASE     (HI_BASE),
      .ACC_REG     (ACC_REG)
   ) u_decode (
      .instr   (instr),
      .ctrl    (dec),
      .rt_used (dec_rt_used)
   );

   // A held LW whose destination feeds the incoming word blocks it until the LW has left.
   always_comb begin
      rs_hit      = (dec.rs == bundle_q.rd);
      rt_hit      = dec_rt_used && (dec.rt == bundle_q.rd);
      hazard      = out_valid_q && bundle_q.mem_read && in_valid && !dec.illegal
                    && (rs_hit || rt_hit);
      in_ready    = !halted_q && !hazard && (!out_valid_q || out_ready);
      accept      = in_valid && in_ready;
      out_valid_d = out_valid_q;
      bundle_d    = bundle_q;
      halted_d    = halted_q;
      if (accept) begin
         out_valid_d = 1'b1;
         bundle_d    = dec;
         if (dec.halt) begin
            halted_d = 1'b1;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
         halted_q    <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         bundle_q    <= bundle_d;
         halted_q    <= halted_d;
      end
   end

   assign out_valid = out_valid_q;
   assign halted    = halted_q;
   assign alu_op    = bundle_q.alu_op;
   assign rs_addr   = AW'(bundle_q.rs);
   assign rt_addr   = AW'(bundle_q.rt);
   assign rd_addr   = AW'(bundle_q.rd);
   assign imm       = REG_WIDTH'(bundle_q.imm);
   assign reg_write = bundle_q.reg_write;
   assign sel_imm   = bundle_q.sel_imm;
   assign mem_read  = bundle_q.mem_read;
   assign mem_write = bundle_q.mem_write;
   assign mem2reg   = bundle_q.mem2reg;
   assign branch    = bundle_q.branch;
   assign jump      = bundle_q.jump;
   assign halt      = bundle_q.halt;
   assign illegal   = bundle_q.illegal;

`ifdef DECODE_PERF_EN
   logic [31:0] perf_decoded_q;
   logic [31:0] perf_decoded_d;
   logic [31:0] perf_stalls_q;
   logic [31:0] perf_stalls_d;

   // Both counters stick at all-ones rather than wrapping.
   always_comb begin
      perf_decoded_d = perf_decoded_q;
      perf_stalls_d  = perf_stalls_q;
      if (accept && (perf_decoded_q != '1)) begin
         perf_decoded_d = perf_decoded_q + 32'd1;
      end
      if (hazard && (perf_stalls_q != '1)) begin
         perf_stalls_d = perf_stalls_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_decoded_q <= '0;
         perf_stalls_q  <= '0;
      end else begin
         perf_decoded_q <= perf_decoded_d;
         perf_stalls_q  <= perf_stalls_d;
      end
   end

   assign perf_decoded = perf_decoded_q;
   assign perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Randomised scoreboard bench for decode_stage, plus a small NUM_REGS=8 instance for range checks.
`timescale 1ns/1ps
module tb_decode_stage;

   localparam int AW  = 4;
   localparam int SAW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          in_valid, in_ready, out_valid, out_ready;
   logic [8:0]    instr;
   logic [3:0]    alu_op;
   logic [AW-1:0] rs_addr, rt_addr, rd_addr;
   logic [7:0]    imm;
   logic          reg_write, sel_imm, mem_read, mem_write, mem2reg, branch, jump;
   logic          halt, illegal, halted;
`ifdef DECODE_PERF_EN
   logic [31:0]   perf_decoded, perf_stalls;
`endif

   logic           sm_in_valid, sm_in_ready, sm_out_valid;
   logic [8:0]     sm_instr;
   logic [3:0]     sm_alu_op;
   logic [SAW-1:0] sm_rs, sm_rt, sm_rd;
   logic [7:0]     sm_imm;
   logic           sm_reg_write, sm_sel_imm, sm_mem_read, sm_mem_write, sm_mem2reg;
   logic           sm_branch, sm_jump, sm_halt, sm_illegal, sm_halted;
`ifdef DECODE_PERF_EN
   logic [31:0]    sm_perf_decoded, sm_perf_stalls;
`endif

   decode_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .imm(imm),
      .reg_write(reg_write), .sel_imm(sel_imm), .mem_read(mem_read), .mem_write(mem_write),
      .mem2reg(mem2reg), .branch(branch), .jump(jump), .halt(halt), .illegal(illegal),
      .halted(halted)
`ifdef DECODE_PERF_EN
      , .perf_decoded(perf_decoded), .perf_stalls(perf_stalls)
`endif
   );

   decode_stage #(.NUM_REGS(8)) u_small (
      .clk(clk), .rst_n(rst_n), .in_valid(sm_in_valid), .in_ready(sm_in_ready),
      .instr(sm_instr), .out_valid(sm_out_valid), .out_ready(1'b1), .alu_op(sm_alu_op),
      .rs_addr(sm_rs), .rt_addr(sm_rt), .rd_addr(sm_rd), .imm(sm_imm),
      .reg_write(sm_reg_write), .sel_imm(sm_sel_imm), .mem_read(sm_mem_read),
      .mem_write(sm_mem_write), .mem2reg(sm_mem2reg), .branch(sm_branch), .jump(sm_jump),
      .halt(sm_halt), .illegal(sm_illegal), .halted(sm_halted)
`ifdef DECODE_PERF_EN
      , .perf_decoded(sm_perf_decoded), .perf_stalls(sm_perf_stalls)
`endif
   );

   typedef struct {
      int alu, rs, rt, rd, imm;
      bit rw, si, mr, mw, m2r, br, j, hl, il, uses_rt;
   } ref_t;

   ref_t sb[$];
   ref_t mHeld;
   bit   mValid, mHalted;
   int   mDecoded, mStalls;
   int   nCompared = 0;
   int   nMismatched = 0;

   // Reference decode written straight from the instruction table (default parameters).
   function automatic ref_t refDecode(input logic [8:0] ins);
      ref_t r;
      int op, s, a, b;
      op = int'(ins[8:6]); a = int'(ins[5:4]); b = int'(ins[3:2]); s = int'(ins[1:0]);
      r = '{default: 0};
      case (op)
         0: begin
            r.rs = a + 4; r.rt = b; r.rd = 11; r.rw = 1; r.uses_rt = 1;
            if (s == 0) r.alu = 0;
            else if (s == 1) begin r.alu = 1; r.rt = b + 8; end
            else if (s == 2) r.alu = 2;
            else begin r.alu = 6; r.j = 1; r.rw = 0; end
         end
         1: begin
            r.rs = a + 4; r.alu = 6;
            if (s == 0) begin r.rd = b; r.mr = 1; r.m2r = 1; r.rw = 1; end
            else if (s == 1) begin r.rt = b; r.mw = 1; r.uses_rt = 1; end
            else r.il = 1;
         end
         2, 6: begin
            r.rs = a + 4; r.rt = b; r.rd = s + 8; r.rw = 1; r.uses_rt = 1;
            r.alu = (op == 2) ? 4 : 5;
         end
         3: begin
            r.rs = a + 4; r.rd = a + 4; r.imm = int'(ins[3:0]); r.si = 1; r.alu = 4; r.rw = 1;
         end
         4: begin
            r.rs = int'(ins[2:0]) + 4; r.rd = int'(ins[5:3]); r.alu = 6; r.rw = 1;
         end
         5: begin
            r.rs = a + 4; r.rt = b; r.alu = 7; r.br = 1; r.uses_rt = 1;
         end
         default: begin
            r.rs = a + 4; r.rd = a + 4; r.rt = b; r.rw = 1; r.uses_rt = 1;
            if (s == 3) begin r.hl = 1; r.rw = 0; end
            else r.alu = 8 + s;
         end
      endcase
      if (r.rs >= 12 || r.rt >= 12 || r.rd >= 12) r.il = 1;
      if (r.il) begin r.rw = 0; r.mr = 0; r.mw = 0; r.m2r = 0; r.br = 0; r.j = 0; end
      return r;
   endfunction

   function automatic logic [63:0] packBundle(input int alu, input int rs, input int rt,
                                              input int rd, input int im,
                                              input logic [8:0] ctl, input bit ctlOnly);
      if (ctlOnly) return {55'd0, ctl};
      return {31'd0, 4'(alu), 4'(rs), 4'(rt), 4'(rd), 8'(im), ctl};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pop the oldest expected bundle whenever the DUT hands one downstream.
   always @(negedge clk) begin : monitor
      ref_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_bundle", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            checkOutput("bundle",
               packBundle(int'(alu_op), int'(rs_addr), int'(rt_addr), int'(rd_addr), int'(imm),
                  {reg_write, sel_imm, mem_read, mem_write, mem2reg, branch, jump, halt, illegal},
                  e.il),
               packBundle(e.alu, e.rs, e.rt, e.rd, e.imm,
                  {e.rw, e.si, e.mr, e.mw, e.m2r, e.br, e.j, e.hl, e.il}, e.il));
         end
      end
   end

   task automatic applyStimulus(input logic v, input logic [8:0] ins, input logic ordy);
      ref_t nd;
      bit   haz, expReady;
      @(posedge clk); #1;
      in_valid = v; instr = ins; out_ready = ordy;
      #1;
      nd  = refDecode(ins);
      haz = mValid && mHeld.mr && v && !nd.il
            && (nd.rs == mHeld.rd || (nd.uses_rt && nd.rt == mHeld.rd));
      expReady = !mHalted && !haz && (!mValid || ordy);
      checkOutput("out_valid", 64'(out_valid), 64'(mValid));
      checkOutput("in_ready", 64'(in_ready), 64'(expReady));
      checkOutput("halted", 64'(halted), 64'(mHalted));
`ifdef DECODE_PERF_EN
      checkOutput("perf_decoded", 64'(perf_decoded), 64'(mDecoded));
      checkOutput("perf_stalls", 64'(perf_stalls), 64'(mStalls));
`endif
      if (haz) mStalls++;
      if (v && expReady) begin
         sb.push_back(nd);
         mHeld = nd;
         mValid = 1;
         mDecoded++;
         if (nd.hl) mHalted = 1;
      end else if (ordy) begin
         mValid = 0;
      end
   endtask

   task automatic doReset();
      @(posedge clk); #1;
      rst_n = 0; in_valid = 0; out_ready = 0;
      @(posedge clk); #1;
      rst_n = 1;
      sb.delete();
      mValid = 0; mHalted = 0; mDecoded = 0; mStalls = 0;
      mHeld = '{default: 0};
      #1;
      checkOutput("reset_state",
         64'({out_valid, halted, alu_op, rs_addr, rt_addr, rd_addr, imm, reg_write, sel_imm,
              mem_read, mem_write, mem2reg, branch, jump, halt, illegal}), 64'd0);
   endtask

   task automatic smallCheck(input string name, input logic [8:0] ins, input bit expIll,
                             input bit expRw);
      @(posedge clk); #1;
      sm_in_valid = 1; sm_instr = ins;
      @(posedge clk); #1;
      sm_in_valid = 0;
      #1;
      checkOutput(name, 64'({sm_out_valid, sm_illegal, sm_reg_write}),
                  64'({1'b1, expIll, expRw}));
   endtask

   initial begin
      in_valid = 0; instr = '0; out_ready = 0;
      sm_in_valid = 0; sm_instr = '0;
      doReset();

      smallCheck("small_add_rd8", 9'b010_00_00_00, 1, 0);
      smallCheck("small_and_acc", 9'b000_00_00_00, 1, 0);
      smallCheck("small_lw_ok", 9'b001_00_01_00, 0, 1);

      applyStimulus(1, 9'b010_01_10_11, 1);
      applyStimulus(0, 9'd0, 1);

      applyStimulus(1, 9'b000_00_00_00, 1);
      repeat (3) applyStimulus(1, 9'b000_01_10_10, 0);
      applyStimulus(1, 9'b000_01_10_10, 1);
      applyStimulus(0, 9'd0, 1);

      applyStimulus(1, 9'b001_00_01_00, 1);
      repeat (4) applyStimulus(1, 9'b010_00_01_00, 1);
      applyStimulus(1, 9'b001_00_00_10, 1);

      applyStimulus(1, 9'b111_00_00_11, 1);
      repeat (4) applyStimulus(1, 9'b110_00_00_00, 1);
      doReset();

      for (int i = 0; i < 3000; i++) begin
         logic [8:0] ri;
         ri = 9'($urandom);
         if (mHalted && ($urandom_range(0, 3) == 0)) doReset();
         else if ($urandom_range(0, 299) == 0) doReset();
         else applyStimulus($urandom_range(0, 3) != 0, ri, $urandom_range(0, 3) != 0);
      end

      repeat (3) applyStimulus(0, 9'd0, 1);
      checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
